fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 21 ++
 rtl/fb_arbiter_if.sv | 44 ++++
 rtl/fb_addr_gen.sv | 30 +++
 rtl/fb_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_fb_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared geometry, pixel type and FSM state encoding for the frame-buffer arbiter.
package fb_pkg;

    localparam int unsigned COLS       = 80;
    localparam int unsigned ROWS       = 60;
    localparam int unsigned AW         = 13;
    localparam int unsigned DW         = 16;
    localparam int unsigned STARVE_MAX = 4;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } fb_state_e;

endpackage

// File: rtl/fb_arbiter_if.sv
// Display-read, capture-write, frame-clear and single-port RAM signals of the arbiter.
interface fb_arbiter_if #(
    parameter int unsigned AW = fb_pkg::AW,
    parameter int unsigned DW = fb_pkg::DW
);

    logic          rd_req;
    logic [6:0]    rd_x;
    logic [6:0]    rd_y;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    logic          wr_valid;
    logic          wr_ready;
    logic [6:0]    wr_x;
    logic [6:0]    wr_y;
    logic [DW-1:0] wr_data;

    logic          clear_req;
    logic          busy;
    logic          wr_oob;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  rd_req, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data, clear_req, mem_rdata,
        output rd_ack, rd_valid, rd_data, wr_ready, busy, wr_oob,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Client and RAM side
    modport master (
        output rd_req, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data, clear_req, mem_rdata,
        input  rd_ack, rd_valid, rd_data, wr_ready, busy, wr_oob,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/fb_addr_gen.sv
// Pixel coordinate to linear RAM address, plus frame range check.
module fb_addr_gen #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 60,
    parameter int unsigned AW   = 13
) (
    input  logic [6:0]    i_x,
    input  logic [6:0]    i_y,
    output logic [AW-1:0] o_addr,
    output logic          o_in_range
);

    logic [AW-1:0] w_x;
    logic [AW-1:0] w_y;

    assign w_x = AW'(i_x);
    assign w_y = AW'(i_y);

    // 80 = 64 + 16, so the row offset is two shifts and an add
    generate
        if (COLS == 80) begin : g_shift
            assign o_addr = (w_y << 6) + (w_y << 4) + w_x;
        end else begin : g_mul
            assign o_addr = (w_y * AW'(COLS)) + w_x;
        end
    endgenerate

    assign o_in_range = (32'(i_x) < COLS) && (32'(i_y) < ROWS);

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: display reads, capture writes and frame clear share one port.
// Optional starvation guard for pending writes: define FB_ARB_FAIRNESS_EN.
module fb_arbiter #(
    parameter int unsigned COLS       = fb_pkg::COLS,
    parameter int unsigned ROWS       = fb_pkg::ROWS,
    parameter int unsigned AW         = fb_pkg::AW,
    parameter int unsigned DW         = fb_pkg::DW,
    parameter int unsigned STARVE_MAX = fb_pkg::STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    fb_arbiter_if.slave   bus
);

    import fb_pkg::*;

    localparam int unsigned   NPIX      = COLS * ROWS;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    fb_state_e     r_state;
    fb_state_e     w_state_nxt;

    logic [AW-1:0] r_clr_addr;
    logic [AW-1:0] w_clr_issue;

    logic [AW-1:0] w_rd_addr;
    logic [AW-1:0] w_wr_addr;
    logic          w_rd_inr;
    logic          w_wr_inr;

    logic          w_force;
    logic          w_rd_grant;
    logic          w_wr_grant;

    logic          w_mem_en;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;

    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic          r_p1_vld;
    logic          r_p1_inr;
    logic          r_p2_vld;
    logic          r_p2_inr;
    logic          r_busy;
    logic          r_wr_oob;

    fb_addr_gen #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_rd_addr (
        .i_x        (bus.rd_x),
        .i_y        (bus.rd_y),
        .o_addr     (w_rd_addr),
        .o_in_range (w_rd_inr)
    );

    fb_addr_gen #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_wr_addr (
        .i_x        (bus.wr_x),
        .i_y        (bus.wr_y),
        .o_addr     (w_wr_addr),
        .o_in_range (w_wr_inr)
    );

    // A clear request restarts the sweep from address 0 in the same cycle
    assign w_clr_issue = bus.clear_req ? '0 : r_clr_addr;

`ifdef FB_ARB_FAIRNESS_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] r_starve_cnt;

    assign w_force = (r_starve_cnt == SW'(STARVE_MAX)) && bus.wr_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if ((r_state != ST_RUN) || !bus.wr_valid || w_wr_grant) begin
            r_starve_cnt <= '0;
        end else if (w_rd_grant && (r_starve_cnt != SW'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end
`else
    assign w_force = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_issue == LAST_ADDR) w_state_nxt = ST_RUN;
            ST_RUN:   if (bus.clear_req)            w_state_nxt = ST_CLEAR;
            default:                                w_state_nxt = ST_CLEAR;
        endcase
    end

    // Grant and RAM command selection; out-of-range requests are granted with no access
    always_comb begin
        w_rd_grant  = 1'b0;
        w_wr_grant  = 1'b0;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (r_state)
            ST_CLEAR: begin
                w_rd_grant = bus.rd_req;
                w_mem_en   = 1'b1;
                w_mem_we   = 1'b1;
                w_mem_addr = w_clr_issue;
            end
            ST_RUN: begin
                w_rd_grant = bus.rd_req && !w_force;
                w_wr_grant = bus.wr_valid && !w_rd_grant;
                if (w_rd_grant && w_rd_inr) begin
                    w_mem_en   = 1'b1;
                    w_mem_addr = w_rd_addr;
                end else if (w_wr_grant && w_wr_inr) begin
                    w_mem_en    = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = w_wr_addr;
                    w_mem_wdata = bus.wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clr_addr <= '0;
        end else if (r_state == ST_RUN) begin
            r_clr_addr <= '0;
        end else begin
            r_clr_addr <= w_clr_issue + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b1;
            r_wr_oob    <= 1'b0;
        end else begin
            r_mem_en    <= w_mem_en;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_busy      <= (r_state == ST_CLEAR) || (w_state_nxt == ST_CLEAR);
            r_wr_oob    <= w_wr_grant && !w_wr_inr;
        end
    end

    // Two-stage read tag pipeline lines up with the RAM's one-cycle latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1_vld <= 1'b0;
            r_p1_inr <= 1'b0;
            r_p2_vld <= 1'b0;
            r_p2_inr <= 1'b0;
        end else begin
            r_p1_vld <= w_rd_grant;
            r_p1_inr <= w_rd_grant && w_rd_inr && (r_state == ST_RUN);
            r_p2_vld <= r_p1_vld;
            r_p2_inr <= r_p1_inr;
        end
    end

    assign bus.rd_ack    = w_rd_grant;
    assign bus.wr_ready  = w_wr_grant;
    assign bus.rd_valid  = r_p2_vld;
    assign bus.rd_data   = r_p2_inr ? bus.mem_rdata : '0;
    assign bus.busy      = r_busy;
    assign bus.wr_oob    = r_wr_oob;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural single-port RAM.
module tb_fb_arbiter;

    import fb_pkg::*;

`ifdef FB_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    fb_arbiter #(
        .COLS(COLS), .ROWS(ROWS), .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, waitc, errs, nwr, rdv;
        bit exp_w;

        rst           = 1'b0;
        bus.rd_req    = 1'b0;
        bus.rd_x      = '0;
        bus.rd_y      = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_x      = '0;
        bus.wr_y      = '0;
        bus.wr_data   = '0;
        bus.clear_req = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) tick();

        check("rst_busy",     bus.busy,      1);
        check("rst_mem_en",   bus.mem_en,    0);
        check("rst_mem_we",   bus.mem_we,    0);
        check("rst_mem_addr", bus.mem_addr,  0);
        check("rst_mem_wdat", bus.mem_wdata, 0);
        check("rst_rd_valid", bus.rd_valid,  0);
        check("rst_rd_data",  bus.rd_data,   0);
        check("rst_wr_oob",   bus.wr_oob,    0);

        // Initial frame clear
        rst   = 1'b1;
        waitc = 0;
        do begin
            tick();
            waitc++;
        end while (!bus.mem_we && waitc < 10);
        check("clr_first_lat", waitc, 1);
        n    = 0;
        errs = 0;
        while (bus.mem_we && n < 5000) begin
            if (bus.mem_addr !== AW'(n) || bus.mem_wdata !== '0 || !bus.busy) errs++;
            n++;
            tick();
        end
        check("clr_count",     n,        4800);
        check("clr_seq",       errs,     0);
        check("clr_busy_fall", bus.busy, 0);

        // Write then read back one pixel
        bus.wr_valid = 1'b1; bus.wr_x = 7'd3; bus.wr_y = 7'd2; bus.wr_data = 16'hF800;
        #1 check("wr_ready", bus.wr_ready, 1);
        tick();
        bus.wr_valid = 1'b0;
        check("wr_mem_en",   bus.mem_en,    1);
        check("wr_mem_we",   bus.mem_we,    1);
        check("wr_mem_addr", bus.mem_addr,  163);
        check("wr_mem_wdat", bus.mem_wdata, 16'hF800);
        bus.rd_req = 1'b1; bus.rd_x = 7'd3; bus.rd_y = 7'd2;
        #1 check("rd_ack", bus.rd_ack, 1);
        tick();
        bus.rd_req = 1'b0;
        check("rd_mem_addr", bus.mem_addr, 163);
        check("rd_mem_we",   bus.mem_we,   0);
        check("rd_valid_t1", bus.rd_valid, 0);
        tick();
        check("rd_valid_t2", bus.rd_valid, 1);
        check("rd_data",     bus.rd_data,  16'hF800);
        tick();
        check("rd_valid_end", bus.rd_valid, 0);

        // Back-to-back reads
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1; bus.wr_x = 7'(i); bus.wr_y = 7'd0;
            bus.wr_data  = (i == 0) ? 16'h1111 : 16'h2222;
            #1 check("b2b_wr_ready", bus.wr_ready, 1);
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.rd_req = 1'b1; bus.rd_x = 7'd0; bus.rd_y = 7'd0;
        tick();
        bus.rd_x = 7'd1;
        tick();
        bus.rd_req = 1'b0;
        check("b2b_valid0", bus.rd_valid, 1);
        check("b2b_data0",  bus.rd_data,  16'h1111);
        tick();
        check("b2b_valid1", bus.rd_valid, 1);
        check("b2b_data1",  bus.rd_data,  16'h2222);
        tick();

        // Read pressure against a pending write
        bus.rd_req   = 1'b1; bus.rd_x = 7'd0; bus.rd_y = 7'd0;
        bus.wr_valid = 1'b1; bus.wr_x = 7'd5; bus.wr_y = 7'd5; bus.wr_data = 16'hABCD;
        errs = 0;
        nwr  = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            exp_w = FAIR && ((i % 5) == 4);
            if (bus.wr_ready !== exp_w || bus.rd_ack !== !exp_w) errs++;
            if (bus.wr_ready) nwr++;
            tick();
        end
        bus.rd_req   = 1'b0;
        bus.wr_valid = 1'b0;
        check("fair_pattern", errs, 0);
        check("fair_writes",  nwr,  FAIR ? 4 : 0);
        repeat (3) tick();

        // Out-of-range read and write
        bus.rd_req = 1'b1; bus.rd_x = 7'd100; bus.rd_y = 7'd10;
        #1 check("oob_rd_ack", bus.rd_ack, 1);
        tick();
        bus.rd_req = 1'b0;
        check("oob_rd_mem_en", bus.mem_en, 0);
        tick();
        check("oob_rd_valid", bus.rd_valid, 1);
        check("oob_rd_data",  bus.rd_data,  0);
        bus.wr_valid = 1'b1; bus.wr_x = 7'd80; bus.wr_y = 7'd0; bus.wr_data = 16'h1234;
        #1 check("oob_wr_ready", bus.wr_ready, 1);
        tick();
        bus.wr_valid = 1'b0;
        check("oob_wr_mem_en", bus.mem_en, 0);
        check("oob_wr_pulse",  bus.wr_oob, 1);
        tick();
        check("oob_wr_end",    bus.wr_oob, 0);

        // Clear request with a read in flight, then a read during clear
        bus.rd_req = 1'b1; bus.rd_x = 7'd3; bus.rd_y = 7'd2;
        tick();
        bus.rd_req    = 1'b0;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        check("flight_valid", bus.rd_valid, 1);
        check("flight_data",  bus.rd_data,  16'hF800);
        check("clr2_busy",    bus.busy,     1);
        tick();
        check("clr2_we",   bus.mem_we,   1);
        check("clr2_addr", bus.mem_addr, 0);
        bus.rd_req   = 1'b1; bus.rd_x = 7'd3; bus.rd_y = 7'd2;
        bus.wr_valid = 1'b1; bus.wr_x = 7'd1; bus.wr_y = 7'd1;
        #1;
        check("clr_rd_ack",   bus.rd_ack,   1);
        check("clr_wr_ready", bus.wr_ready, 0);
        tick();
        bus.rd_req   = 1'b0;
        bus.wr_valid = 1'b0;
        check("clr_rd_noacc", bus.mem_we,   1);
        check("clr_rd_addr",  bus.mem_addr, 1);
        tick();
        check("clr_rd_valid", bus.rd_valid, 1);
        check("clr_rd_data",  bus.rd_data,  0);

        // Restart mid-clear
        waitc = 0;
        while (bus.mem_addr !== AW'(1999) && waitc < 3000) begin
            tick();
            waitc++;
        end
        check("clr_reach_1999", bus.mem_addr, 1999);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        check("restart_addr0", bus.mem_addr, 0);
        check("restart_we",    bus.mem_we,   1);
        tick();
        check("restart_addr1", bus.mem_addr, 1);

        // Reset while a read is in flight
        waitc = 0;
        while (bus.busy && waitc < 6000) begin
            tick();
            waitc++;
        end
        check("run_reached", bus.busy, 0);
        bus.rd_req = 1'b1; bus.rd_x = 7'd3; bus.rd_y = 7'd2;
        tick();
        bus.rd_req = 1'b0;
        rst        = 1'b0;
        #1;
        check("rst_mid_mem_en", bus.mem_en, 0);
        rdv = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.rd_valid) rdv++;
            tick();
            if (i == 1) rst = 1'b1;
        end
        check("rst_mid_read", rdv, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
